// File: rtl/branch_unit.sv
// Branch unit: latches ALU status {V, N, Z}, resolves conditional branches through
// a three-state IDLE/EVAL/UPDATE sequence and owns the program counter.
module branch_unit #(
    parameter int PC_W  = 9,
    parameter int OFF_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_status,
    input  logic [2:0]       status_in,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [OFF_W-1:0] br_offset,
    input  logic             pc_inc,
    output logic [PC_W-1:0]  pc,
    output logic [2:0]       status_q,
    output logic             taken,
    output logic             done,
    output logic             illegal
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       cond_q;
    logic [OFF_W-1:0] off_q;
    logic             taken_q, illegal_q;
    logic             accept;
    logic             cond_hit, cond_bad;
    logic [PC_W-1:0]  pc_nxt;
    logic [PC_W-1:0]  off_sext;

    logic stat_v, stat_n, stat_z;
    assign stat_v = status_q[2];
    assign stat_n = status_q[1];
    assign stat_z = status_q[0];

    // Reset forces the handshake closed even in the IDLE state.
    assign br_ready = (state == IDLE) && !reset;
    assign accept   = br_valid && br_ready;
    assign done     = (state == UPDATE) && !reset;
    assign taken    = done && taken_q;
    assign illegal  = done && illegal_q;
    assign off_sext = {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cond_hit = 1'b0;
        cond_bad = 1'b0;
        unique case (cond_q)
            3'b000:  cond_hit = 1'b1;
            3'b001:  cond_hit = stat_z;
            3'b010:  cond_hit = !stat_z;
            3'b011:  cond_hit = stat_n ^ stat_v;
            3'b100:  cond_hit = (stat_n ^ stat_v) | stat_z;
            default: cond_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = EVAL;
                else if (pc_inc)
                    pc_nxt = pc + PC_W'(1);
            end
            EVAL:   state_nxt = UPDATE;
            UPDATE: begin
                state_nxt = IDLE;
                pc_nxt    = pc + PC_W'(1) + (taken_q ? off_sext : '0);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            status_q  <= '0;
            cond_q    <= '0;
            off_q     <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (load_status)
                status_q <= status_in;
            if (accept) begin
                cond_q <= br_cond;
                off_q  <= br_offset;
            end
            // Result is frozen here so a status load during EVAL cannot affect it.
            if (state == EVAL) begin
                taken_q   <= cond_hit;
                illegal_q <= cond_bad;
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: inputs driven and outputs sampled on the falling
// edge, expected values hand-computed from the condition-code table.
module tb_branch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_status;
    logic [2:0] status_in;
    logic       br_valid;
    logic       br_ready;
    logic [2:0] br_cond;
    logic [7:0] br_offset;
    logic       pc_inc;
    logic [8:0] pc;
    logic [2:0] status_q;
    logic       taken, done, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_unit #(.PC_W(9), .OFF_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_status(load_status),
        .status_in  (status_in),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_cond    (br_cond),
        .br_offset  (br_offset),
        .pc_inc     (pc_inc),
        .pc         (pc),
        .status_q   (status_q),
        .taken      (taken),
        .done       (done),
        .illegal    (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return on the falling edge where outputs are stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic branch(input logic [2:0] cond, input logic [7:0] off,
                          input logic exp_taken, input logic exp_illegal,
                          input logic [8:0] exp_pc);
        br_valid  = 1'b1;
        br_cond   = cond;
        br_offset = off;
        #1 check("br_ready_idle", br_ready, 1);
        tick();
        br_valid = 1'b0;
        #1 check("eval_done", done, 0);
        tick();
        check("upd_done", done, 1);
        check("upd_taken", taken, exp_taken);
        check("upd_illegal", illegal, exp_illegal);
        tick();
        check("br_pc", pc, exp_pc);
        check("post_done", done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; load_status = 1'b0; status_in = 3'b000;
        br_valid = 1'b0; br_cond = 3'b000; br_offset = 8'h00; pc_inc = 1'b0;

        // 1: reset, then sequential fetch
        @(negedge clk);
        check("rst_ready", br_ready, 0);
        check("rst_done", done, 0);
        tick();
        check("rst_pc", pc, 0);
        check("rst_status", status_q, 0);
        reset = 1'b0;
        #1 check("post_rst_ready", br_ready, 1);
        pc_inc = 1'b1;
        tick(); check("inc_pc1", pc, 1);
        tick(); check("inc_pc2", pc, 2);
        tick(); check("inc_pc3", pc, 3);
        pc_inc = 1'b0;

        // 2: BEQ taken on Z, offset 5 from pc 3
        load_status = 1'b1; status_in = 3'b001;
        tick();
        load_status = 1'b0;
        check("status_z", status_q, 3'b001);
        br_valid = 1'b1; br_cond = 3'b001; br_offset = 8'h05;
        #1 check("beq_ready", br_ready, 1);
        tick();
        br_valid = 1'b0; br_cond = 3'b111; br_offset = 8'hFF;
        #1 check("beq_eval_ready", br_ready, 0);
        check("beq_eval_done", done, 0);
        tick();
        check("beq_done", done, 1);
        check("beq_taken", taken, 1);
        check("beq_illegal", illegal, 0);
        check("beq_pc_hold", pc, 3);
        tick();
        check("beq_pc", pc, 9);
        check("beq_done_end", done, 0);
        check("beq_ready_end", br_ready, 1);

        // 3: BLT then BLE on V=1 N=1 Z=0 with br_valid and pc_inc held high
        load_status = 1'b1; status_in = 3'b110;
        tick();
        load_status = 1'b0;
        check("status_vn", status_q, 3'b110);
        br_valid = 1'b1; br_cond = 3'b011; br_offset = 8'h10; pc_inc = 1'b1;
        tick();
        br_cond = 3'b100;
        #1 check("blt_eval_ready", br_ready, 0);
        tick();
        check("blt_done", done, 1);
        check("blt_taken", taken, 0);
        tick();
        check("blt_pc", pc, 10);
        check("blt_done_end", done, 0);
        check("ble_ready", br_ready, 1);
        tick();
        br_valid = 1'b0;
        #1 check("ble_eval_ready", br_ready, 0);
        tick();
        check("ble_done", done, 1);
        check("ble_taken", taken, 0);
        pc_inc = 1'b0;
        tick();
        check("ble_pc", pc, 11);
        check("ble_done_end", done, 0);

        // 4: wrap-around in both directions
        branch(3'b000, 8'hF2, 1, 0, 9'h1FE);
        branch(3'b000, 8'hFC, 1, 0, 9'h1FB);
        pc_inc = 1'b1;
        tick(); tick(); tick(); tick();
        check("wrap_pc_1ff", pc, 9'h1FF);
        tick();
        check("wrap_pc_0", pc, 9'h000);
        pc_inc = 1'b0;

        // 5: illegal code, then status load during EVAL of a BNE
        branch(3'b110, 8'h20, 0, 1, 9'h001);
        load_status = 1'b1; status_in = 3'b000;
        tick();
        load_status = 1'b0;
        br_valid = 1'b1; br_cond = 3'b010; br_offset = 8'h03;
        tick();
        br_valid = 1'b0;
        load_status = 1'b1; status_in = 3'b010;
        tick();
        load_status = 1'b0;
        check("bne_done", done, 1);
        check("bne_taken", taken, 1);
        tick();
        check("bne_pc", pc, 9'h005);
        check("bne_status", status_q, 3'b010);

        // 6: reset during EVAL abandons the branch
        branch(3'b000, 8'h3A, 1, 0, 9'h040);
        br_valid = 1'b1; br_cond = 3'b010; br_offset = 8'h05;
        tick();
        br_valid = 1'b0;
        reset = 1'b1;
        #1 check("mid_rst_ready", br_ready, 0);
        check("mid_rst_done", done, 0);
        tick();
        reset = 1'b0;
        #1 check("abandon_done", done, 0);
        check("abandon_pc", pc, 0);
        check("abandon_status", status_q, 0);
        check("abandon_ready", br_ready, 1);
        tick();
        check("abandon_done2", done, 0);
        check("abandon_pc2", pc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Consumer end of the ALU status interface. Latches the 3-bit {overflow, negative, zero} status word into a status register.
- Evaluates branch condition codes against the latched status and owns the 9-bit program counter.
- Sits between the ALU/status generator and instruction fetch. Branch requests use a valid/ready handshake; the block reports taken/not-taken and advances the PC.

Parameters:
PC_W, 9, program counter width; arithmetic wraps modulo 2^PC_W
OFF_W, 8, branch offset width; two's complement, sign-extended to PC_W

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
load_status  in  1  capture status_in into the status register at this edge
status_in  in  3  {V, N, Z} from the ALU status generator (bit2 = V, bit1 = N, bit0 = Z)
br_valid  in  1  branch request valid
br_ready  out  1  block can accept a branch request
br_cond  in  3  condition code, sampled on accept
br_offset  in  OFF_W  signed offset, sampled on accept
pc_inc  in  1  sequential-fetch increment request
pc  out  PC_W  current program counter
status_q  out  3  latched status {V, N, Z}
taken  out  1  valid with done; 1 = branch taken
done  out  1  one-cycle pulse: branch resolved, PC update at this edge
illegal  out  1  one-cycle pulse with done when br_cond is unused

Behaviour:
- Reset (sync, active-high; wins over every other input):
  - pc = 0, status_q = 0, state = IDLE.
  - taken = 0, done = 0, illegal = 0.
  - br_ready = 0 during any cycle where reset is high, and 1 in the first IDLE cycle after it.
- Status register:
  - status_q <= status_in on any edge with load_status = 1, in every state.
  - Otherwise status_q holds.
- Condition codes, evaluated on status_q as {V, N, Z}:
  - 000: always taken
  - 001: taken if Z
  - 010: taken if !Z
  - 011: taken if N != V
  - 100: taken if (N != V) | Z
  - 101-111: not taken, illegal = 1
- FSM states: IDLE, EVAL, UPDATE.
- IDLE:
  - br_ready = 1.
  - Accept when br_valid & br_ready. Latch br_cond and br_offset, then go to EVAL.
  - Without an accept, pc_inc = 1 gives pc <= pc + 1.
  - pc_inc is ignored in the accept cycle.
- EVAL:
  - br_ready = 0.
  - Compute the condition from status_q as it stands during EVAL, which includes a load made in the accept cycle.
  - Register the taken result, then go to UPDATE.
  - A load_status in EVAL updates status_q but does not affect this branch.
- UPDATE:
  - br_ready = 0, done = 1, taken = the registered result, illegal as computed.
  - At this edge: pc <= pc + 1 + sext(br_offset) if taken, else pc <= pc + 1. Then return to IDLE.
- Latency: accept at edge T, done high in cycle T+2, new pc visible after edge T+2. Next accept is possible at edge T+3.
- pc_inc is ignored in EVAL and UPDATE, with no queuing.
- br_cond, br_offset and br_valid changes after accept have no effect.
- Arithmetic: all PC sums are truncated to PC_W bits. Wrap-around in either direction is silent (0x1FF + 1 = 0x000; 0x000 + 1 + sext(-2) = 0x1FF).
- Reset mid-branch (EVAL or UPDATE): the branch is abandoned, no done pulse, pc = 0.
- taken and illegal are 0 whenever done = 0.

Test Plan:
1. Reset then 3 cycles of pc_inc = 1 -> pc = 0, 1, 2, 3; br_ready = 1 from the first post-reset cycle; status_q = 000.
2. load_status with status_in = 001 (Z); request BEQ (001), offset 0x05, at pc = 3 -> done and taken = 1 two cycles after accept; pc = 9 afterwards.
3. status_in = 110 (V = 1, N = 1, Z = 0); BLT (011) and BLE (100) with offset 0x10 at pc = 9 -> both taken = 0; pc increments by 1 per branch; done pulses once each; br_valid held high gives accepts no closer than 3 cycles apart.
4. pc = 0x1FE; B (000) with offset 0xFC (-4) -> pc = 0x1FB. Then pc = 0x1FF with pc_inc -> pc = 0x000.
5. br_cond = 110 -> done = 1, illegal = 1, taken = 0, pc + 1. Then load_status 000 -> 010 asserted in the EVAL cycle of a BNE -> taken = 1 (evaluated on 000, Z = 0) and status_q = 010 afterwards.
6. Assert reset during EVAL of a taken branch at pc = 0x40 -> no done pulse; pc = 0, status_q = 0, state IDLE; br_ready = 1 in the next cycle.
